// File: rtl/bloom_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bloom_seq_ctrl
// Description : Sequences one custom op (insert/check/clear) into the Bloom
//               filter datapath one key byte at a time, returns valid+result.
// Revision    : 1.0 - initial release
// ============================================================================
module bloom_seq_ctrl #(
    parameter int NUM_BYTES  = 4,
    parameter int CLR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        custom_en,
    input  logic [4:0]  custom_op_ex,
    input  logic [31:0] custom_in_RS1,
    output logic        custom_busy,
    output logic        custom_valid,
    output logic [31:0] custom_result,
    output logic        custom_illegal,
    output logic        bloom_insert,
    output logic        bloom_check,
    output logic        bloom_reset,
    output logic [31:0] bloom_data,
    input  logic        bloom_match
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [4:0]       c_op_insert = 5'b00001;
    localparam logic [4:0]       c_op_clear  = 5'b00011;
    localparam logic [4:0]       c_op_check  = 5'b00100;
    localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] c_clr_last  = CNT_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INS     = 3'd1,
        S_CHK_ISS = 3'd2,
        S_CHK_SMP = 3'd3,
        S_CLR     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q,   state_d;
    logic [31:0]       key_q,     key_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              hit_q,     hit_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [31:0]       result_q,  result_d;
    logic [7:0]        w_cur_byte;
    logic              w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            illegal_q <= 1'b0;
            clr_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            illegal_q <= illegal_d;
            clr_cnt_q <= clr_cnt_d;
            result_q  <= result_d;
        end
    end

    // Byte i of the captured key, LSB first.
    always_comb begin
        w_cur_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_cur_byte = key_q[8*i +: 8];
            end
        end
    end

    assign w_last = (idx_q == c_idx_last);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        illegal_d = illegal_q;
        clr_cnt_d = clr_cnt_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (custom_en) begin
                    key_d     = custom_in_RS1;
                    idx_d     = '0;
                    hit_d     = 1'b1;
                    clr_cnt_d = '0;
                    illegal_d = 1'b0;
                    result_d  = '0;
                    case (custom_op_ex)
                        c_op_insert: state_d = S_INS;
                        c_op_check:  state_d = S_CHK_ISS;
                        c_op_clear:  state_d = S_CLR;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = S_DONE;
                        end
                    endcase
                end
            end
            S_INS: begin
                if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_CHK_ISS: begin
                state_d = S_CHK_SMP;
            end
            S_CHK_SMP: begin
                hit_d = hit_q & bloom_match;
                // A miss on any byte settles the answer; skip the rest.
                if (!bloom_match || w_last) begin
                    result_d = {31'b0, hit_q & bloom_match};
                    state_d  = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_CHK_ISS;
                end
            end
            S_CLR: begin
                if (clr_cnt_q == c_clr_last) begin
                    state_d = S_DONE;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state flop so reset clears them at once.
    always_comb begin
        custom_busy    = (state_q != S_IDLE);
        custom_valid   = (state_q == S_DONE);
        custom_illegal = (state_q == S_DONE) && illegal_q;
        custom_result  = result_q;
        bloom_insert   = (state_q == S_INS);
        bloom_check    = (state_q == S_CHK_ISS);
        bloom_reset    = (state_q == S_CLR);
        bloom_data     = '0;
        if ((state_q == S_INS) || (state_q == S_CHK_ISS)) begin
            bloom_data = {24'b0, w_cur_byte};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bloom_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bloom_seq_ctrl
// Description : Scoreboard bench for bloom_seq_ctrl with a behavioural filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bloom_seq_ctrl;

    localparam logic [4:0] OP_INS = 5'b00001;
    localparam logic [4:0] OP_CLR = 5'b00011;
    localparam logic [4:0] OP_CHK = 5'b00100;
    localparam logic [4:0] OP_BAD = 5'b00111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        custom_en = 1'b0;
    logic [4:0]  custom_op_ex = '0;
    logic [31:0] custom_in_RS1 = '0;
    logic        custom_busy, custom_valid, custom_illegal;
    logic [31:0] custom_result;
    logic        bloom_insert, bloom_check, bloom_reset;
    logic [31:0] bloom_data;
    logic        bloom_match = 1'b0;

    bloom_seq_ctrl #(.NUM_BYTES(4), .CLR_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .custom_en(custom_en), .custom_op_ex(custom_op_ex), .custom_in_RS1(custom_in_RS1),
        .custom_busy(custom_busy), .custom_valid(custom_valid), .custom_result(custom_result),
        .custom_illegal(custom_illegal),
        .bloom_insert(bloom_insert), .bloom_check(bloom_check), .bloom_reset(bloom_reset),
        .bloom_data(bloom_data), .bloom_match(bloom_match)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] kind; logic [7:0] data; } strobe_t;
    typedef struct { int cyc; logic [31:0] res; logic ill; } comp_t;

    strobe_t sq[$];
    comp_t   cq[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   valid_cnt = 0;
    int   acc_cyc  = 0;
    int   done_cyc = -1;
    bit   mon_en   = 1'b0;
    logic [255:0] fset = '0;
    bit   force_en = 1'b0;
    logic [7:0] force_byte = '0;
    logic       mc;
    logic [7:0] md;

    always @(posedge clk) cyc++;

    // Filter model: answers a lookup one cycle after bloom_check.
    always @(posedge clk) begin
        mc = bloom_check;
        md = bloom_data[7:0];
        #1 bloom_match = mc && fset[md] && !(force_en && md == force_byte);
    end

    always @(negedge clk) begin
        if (!rst) begin
            strobe_t s;
            comp_t   c;
            logic [1:0] k;
            logic       busy_exp;
            if (custom_valid) valid_cnt++;
            n_checks++;
            if ((int'(bloom_insert) + int'(bloom_check) + int'(bloom_reset)) > 1 ||
                (!(bloom_insert || bloom_check) && bloom_data != 32'd0)) begin
                n_fail++;
                $display("FAIL strobe_exclusive cyc=%0d ins=%b chk=%b rst=%b data=%h, required one-hot and data 0",
                         cyc, bloom_insert, bloom_check, bloom_reset, bloom_data);
            end
            if (mon_en) begin
                k = bloom_insert ? 2'd1 : bloom_check ? 2'd2 : bloom_reset ? 2'd3 : 2'd0;
                if (k != 2'd0) begin
                    n_checks++;
                    if (sq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_strobe cyc=%0d kind=%0d data=%h, required none", cyc, k, bloom_data);
                    end else begin
                        s = sq.pop_front();
                        if (k !== s.kind || (k != 2'd3 && bloom_data[7:0] !== s.data)) begin
                            n_fail++;
                            $display("FAIL strobe cyc=%0d got kind=%0d data=%h, required kind=%0d data=%h",
                                     cyc, k, bloom_data[7:0], s.kind, s.data);
                        end
                    end
                end
                busy_exp = (done_cyc >= 0) && (cyc > acc_cyc) && (cyc <= done_cyc);
                n_checks++;
                if (custom_busy !== busy_exp) begin
                    n_fail++;
                    $display("FAIL busy cyc=%0d got %b required %b", cyc, custom_busy, busy_exp);
                end
                if (custom_valid) begin
                    n_checks++;
                    if (cq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_valid cyc=%0d, required no valid", cyc);
                    end else begin
                        c = cq.pop_front();
                        if (cyc != c.cyc || custom_result !== c.res || custom_illegal !== c.ill) begin
                            n_fail++;
                            $display("FAIL completion got cyc=%0d res=%h ill=%b, required cyc=%0d res=%h ill=%b",
                                     cyc, custom_result, custom_illegal, c.cyc, c.res, c.ill);
                        end
                    end
                end
            end
            if (bloom_insert) fset[bloom_data[7:0]] = 1'b1;
            if (bloom_reset)  fset = '0;
        end
    end

    task automatic push_bytes(input logic [1:0] kind, input logic [31:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] sh;
            sh = key >> (8 * i);
            sq.push_back('{kind, sh[7:0]});
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic issue(input logic [4:0] op, input logic [31:0] key, input int lat,
                         input logic [31:0] res, input logic ill, input bit poke);
        custom_en = 1'b1; custom_op_ex = op; custom_in_RS1 = key;
        acc_cyc = cyc; done_cyc = cyc + lat;
        cq.push_back('{cyc + lat, res, ill});
        @(negedge clk);
        custom_en = poke; custom_op_ex = OP_INS; custom_in_RS1 = $urandom;
        for (int i = 0; i < 40; i++) begin
            if (cq.size() == 0) break;
            @(negedge clk); #1;
        end
        custom_en = 1'b0;
        n_checks++;
        if (cq.size() != 0) begin
            n_fail++;
            $display("FAIL valid_timeout op=%b pending=%0d required 0", op, cq.size());
            cq.delete();
        end
        n_checks++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobes op=%b pending=%0d required 0", op, sq.size());
            sq.delete();
        end
        @(negedge clk);
        n_checks++;
        if (custom_result !== res || custom_valid !== 1'b0 || custom_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold op=%b got res=%h valid=%b busy=%b required res=%h valid=0 busy=0",
                     op, custom_result, custom_valid, custom_busy, res);
        end
    endtask

    task automatic test_reset();
        int v0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({custom_busy, custom_valid, custom_illegal, bloom_insert, bloom_check, bloom_reset} !== 6'b0 ||
            custom_result !== 32'd0 || bloom_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b valid=%b res=%h data=%h required all 0",
                     custom_busy, custom_valid, custom_result, bloom_data);
        end
        rst = 1'b0;
        @(negedge clk);
        custom_en = 1'b1; custom_op_ex = OP_INS; custom_in_RS1 = 32'h11223344;
        @(negedge clk);
        custom_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bloom_insert !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre_ins got %b required 1", bloom_insert);
        end
        v0 = valid_cnt;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({custom_busy, custom_valid, custom_illegal, bloom_insert, bloom_check, bloom_reset} !== 6'b0 ||
            bloom_data !== 32'd0 || custom_result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop got busy=%b ins=%b data=%h required all 0", custom_busy, bloom_insert, bloom_data);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (valid_cnt != v0 || custom_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_valid got valids=%0d busy=%b required 0 and 0", valid_cnt - v0, custom_busy);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_insert();
        push_bytes(2'd1, 32'hA1B2C3D4, 4);
        issue(OP_INS, 32'hA1B2C3D4, 5, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_check_hit();
        push_bytes(2'd2, 32'hA1B2C3D4, 4);
        issue(OP_CHK, 32'hA1B2C3D4, 9, 32'd1, 1'b0, 1'b0);
    endtask

    task automatic test_check_miss();
        force_en = 1'b1; force_byte = 8'hC3;
        push_bytes(2'd2, 32'hA1B2C3D4, 2);
        issue(OP_CHK, 32'hA1B2C3D4, 5, 32'd0, 1'b0, 1'b0);
        force_en = 1'b0;
    endtask

    task automatic test_clear();
        push_bytes(2'd3, 32'd0, 2);
        issue(OP_CLR, 32'hFFFF_FFFF, 3, 32'd0, 1'b0, 1'b1);
        push_bytes(2'd2, 32'hA1B2C3D4, 1);
        issue(OP_CHK, 32'hA1B2C3D4, 3, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        issue(OP_BAD, 32'hDEADBEEF, 1, 32'd0, 1'b1, 1'b0);
        push_bytes(2'd1, 32'h5A69788A, 4);
        issue(OP_INS, 32'h5A69788A, 5, 32'd0, 1'b0, 1'b0);
        push_bytes(2'd2, 32'h5A69788A, 4);
        issue(OP_CHK, 32'h5A69788A, 9, 32'd1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_insert();
        test_check_hit();
        test_check_miss();
        test_clear();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
